phase_acc_multi: RTL and testbench

PHASE_ACC_MULTI -- requirements
Module: phase_acc_multi

---
 rtl/phase_acc_multi.sv | 129 ++++++++++++
 tb/tb_phase_acc_multi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_acc_multi.sv
// rtl/phase_acc_multi.sv - multi-channel time-interleaved phase accumulator
//
// Purpose: keeps one phase accumulator and one increment per channel.
// Channels are served round-robin, one per accepted input beat. A control
// beat (i_tlast=1) loads that channel's increment and zeroes its phase. A
// data beat (i_tlast=0) emits the channel's current phase and then advances
// it. Results leave through a single output register, one cycle later.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   clear            synchronous active-high soft clear (same effect as reset)
//   i_tdata          increment value, used on control beats only
//   i_tlast          1 = control beat, 0 = data beat
//   i_tvalid         input beat valid
//   i_tready         input ready
//   o_tdata          phase output
//   o_tlast          1 = acknowledgement of a control beat
//   o_tvalid         output beat valid
//   o_tchan          channel index of the output beat
//   o_tready         downstream ready
module phase_acc_multi #(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 1,
  parameter int PHASE_MAX = 16384,
  parameter int WRAP_MODE = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  output logic [CH_W-1:0]  o_tchan,
  input  logic             o_tready
);

  // Wrap and clamp limits at the width of the value they are compared with.
  localparam logic signed [WIDTH-1:0] PM_POS_W = WIDTH'(PHASE_MAX);
  localparam logic signed [WIDTH-1:0] PM_NEG_W = WIDTH'(-PHASE_MAX);
  localparam logic signed [WIDTH:0]   PM_POS_S = (WIDTH+1)'(PHASE_MAX);
  localparam logic signed [WIDTH:0]   PM_NEG_S = (WIDTH+1)'(-PHASE_MAX);
  localparam logic signed [WIDTH:0]   PM_TWO_S = (WIDTH+1)'(2 * PHASE_MAX);
  localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CH - 1);

  logic signed [WIDTH-1:0] acc [NUM_CH];
  logic signed [WIDTH-1:0] inc [NUM_CH];
  logic [CH_W-1:0]         ch;

  logic                    accept;
  logic [CH_W-1:0]         ch_next;
  logic signed [WIDTH-1:0] cur_acc;
  logic signed [WIDTH-1:0] cur_inc;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH:0]   sum_wrapped;
  logic signed [WIDTH-1:0] acc_next;
  logic signed [WIDTH-1:0] inc_load;

  // Ready only when the output register is free or drains this cycle; a
  // stalled output therefore freezes all channel state as well.
  assign i_tready = ~clear & (o_tready | ~o_tvalid);
  // Reset is excluded explicitly so a beat presented during reset is dropped.
  assign accept   = i_tvalid & i_tready & ~reset;
  assign ch_next  = (ch == CH_LAST) ? '0 : ch + 1'b1;

  assign cur_acc  = acc[ch];
  assign cur_inc  = inc[ch];

  always_comb begin
    sum         = {cur_acc[WIDTH-1], cur_acc} + {cur_inc[WIDTH-1], cur_inc};
    sum_wrapped = sum;
    // |inc| <= PHASE_MAX and |acc| <= PHASE_MAX, so one correction suffices.
    if (WRAP_MODE == 1) begin
      if (sum >= PM_POS_S) begin
        sum_wrapped = sum - PM_TWO_S;
      end else if (sum < PM_NEG_S) begin
        sum_wrapped = sum + PM_TWO_S;
      end
    end
    acc_next = sum_wrapped[WIDTH-1:0];
  end

  always_comb begin
    inc_load = $signed(i_tdata);
    if (WRAP_MODE == 1) begin
      if ($signed(i_tdata) > PM_POS_W) begin
        inc_load = PM_POS_W;
      end else if ($signed(i_tdata) < PM_NEG_W) begin
        inc_load = PM_NEG_W;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        inc[c] <= '0;
      end
      ch       <= '0;
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tchan  <= '0;
    end else if (accept) begin
      o_tvalid <= 1'b1;
      o_tchan  <= ch;
      ch       <= ch_next;
      if (i_tlast) begin
        inc[ch]  <= inc_load;
        acc[ch]  <= '0;
        o_tdata  <= '0;
        o_tlast  <= 1'b1;
      end else begin
        acc[ch]  <= acc_next;
        o_tdata  <= cur_acc;
        o_tlast  <= 1'b0;
      end
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_acc_multi.sv
// tb/tb_phase_acc_multi.sv - directed self-checking bench for phase_acc_multi
module tb_phase_acc_multi;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [15:0] i_tdata;
  logic [7:0]  i_tdata8;
  logic        i_tlast;
  logic        i_tvalid;
  logic        o_tready;

  // Instance a: defaults (WIDTH 16, 1 channel, symmetric wrap at 16384)
  logic        a_i_tready, a_o_tlast, a_o_tvalid;
  logic [15:0] a_o_tdata;
  logic [0:0]  a_o_tchan;
  // Instance b: 2 channels
  logic        b_i_tready, b_o_tlast, b_o_tvalid;
  logic [15:0] b_o_tdata;
  logic [0:0]  b_o_tchan;
  // Instance c: WIDTH 8, natural wrap
  logic        c_i_tready, c_o_tlast, c_o_tvalid;
  logic [7:0]  c_o_tdata;
  logic [0:0]  c_o_tchan;

  int n_tests = 0;
  int n_fail  = 0;

  phase_acc_multi u_dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(a_i_tready),
    .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_tvalid(a_o_tvalid),
    .o_tchan(a_o_tchan), .o_tready(o_tready)
  );

  phase_acc_multi #(.NUM_CH(2)) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(b_i_tready),
    .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_tvalid(b_o_tvalid),
    .o_tchan(b_o_tchan), .o_tready(o_tready)
  );

  phase_acc_multi #(.WIDTH(8), .PHASE_MAX(32), .WRAP_MODE(0)) u_dut_c (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata8), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(c_i_tready),
    .o_tdata(c_o_tdata), .o_tlast(c_o_tlast), .o_tvalid(c_o_tvalid),
    .o_tchan(c_o_tchan), .o_tready(o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
  endtask

  // Present one beat, let it be accepted, sample one step after the edge.
  task automatic beat(input logic last, input int data);
    i_tvalid = 1'b1;
    i_tlast  = last;
    i_tdata  = data[15:0];
    i_tdata8 = data[7:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  int exp_a [5] = '{0, 4096, 8192, 12288, -16384};
  int exp_clamp [4] = '{0, -16384, 0, -16384};
  int exp_b_d [4] = '{0, 0, 100, 200};
  int exp_c [4] = '{0, 100, -56, 44};

  initial begin
    clear    = 1'b0;
    o_tready = 1'b1;
    i_tdata  = '0;
    i_tdata8 = '0;
    do_reset();

    check("rst_a_tvalid", a_o_tvalid, 0);
    check("rst_a_tdata", $signed(a_o_tdata), 0);
    check("rst_a_tlast", a_o_tlast, 0);
    check("rst_a_tchan", a_o_tchan, 0);
    check("rst_a_itready", a_i_tready, 1);
    check("rst_b_tvalid", b_o_tvalid, 0);

    // Basic ramp with symmetric wrap
    beat(1'b1, 4096);
    check("ramp_ctl_tdata", $signed(a_o_tdata), 0);
    check("ramp_ctl_tlast", a_o_tlast, 1);
    check("ramp_ctl_tvalid", a_o_tvalid, 1);
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, 16'h1234);
      check($sformatf("ramp_d%0d", k), $signed(a_o_tdata), exp_a[k]);
      check($sformatf("ramp_tlast%0d", k), a_o_tlast, 0);
    end
    idle();
    @(posedge clk); #1;
    check("ramp_drain_tvalid", a_o_tvalid, 0);

    // Increment clamp, positive then negative
    do_reset();
    beat(1'b1, 20000);
    check("clamp_ctl_tlast", a_o_tlast, 1);
    for (int k = 0; k < 4; k++) begin
      beat(1'b0, 0);
      check($sformatf("clamp_d%0d", k), $signed(a_o_tdata), exp_clamp[k]);
    end
    beat(1'b1, -20000);
    check("nclamp_ctl_tdata", $signed(a_o_tdata), 0);
    beat(1'b0, 0);
    check("nclamp_d0", $signed(a_o_tdata), 0);
    beat(1'b0, 0);
    check("nclamp_d1", $signed(a_o_tdata), -16384);
    beat(1'b0, 0);
    check("nclamp_d2", $signed(a_o_tdata), 0);

    // Two channels interleaved
    do_reset();
    beat(1'b1, 100);
    check("ch2_ctl0_tchan", b_o_tchan, 0);
    check("ch2_ctl0_tlast", b_o_tlast, 1);
    beat(1'b1, 200);
    check("ch2_ctl1_tchan", b_o_tchan, 1);
    check("ch2_ctl1_tdata", $signed(b_o_tdata), 0);
    for (int k = 0; k < 4; k++) begin
      beat(1'b0, 0);
      check($sformatf("ch2_d%0d", k), $signed(b_o_tdata), exp_b_d[k]);
      check($sformatf("ch2_chan%0d", k), b_o_tchan, k % 2);
    end

    // Backpressure on b: acc0=200, acc1=400, next channel 0
    beat(1'b0, 0);
    check("bp_pre_tdata", $signed(b_o_tdata), 200);
    o_tready = 1'b0;
    #1;
    check("bp_pre_itready", b_i_tready, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_tdata%0d", k), $signed(b_o_tdata), 200);
      check($sformatf("bp_hold_tchan%0d", k), b_o_tchan, 0);
      check($sformatf("bp_hold_tvalid%0d", k), b_o_tvalid, 1);
      check($sformatf("bp_hold_itready%0d", k), b_i_tready, 0);
    end
    o_tready = 1'b1;
    beat(1'b0, 0);
    check("bp_resume0_tdata", $signed(b_o_tdata), 400);
    check("bp_resume0_tchan", b_o_tchan, 1);
    beat(1'b0, 0);
    check("bp_resume1_tdata", $signed(b_o_tdata), 300);
    check("bp_resume1_tchan", b_o_tchan, 0);

    // Soft clear mid-stream on b
    i_tvalid = 1'b1;
    i_tlast  = 1'b0;
    clear    = 1'b1;
    #1;
    check("clr_itready", b_i_tready, 0);
    @(posedge clk); #1;
    clear    = 1'b0;
    check("clr_tvalid", b_o_tvalid, 0);
    check("clr_tdata", $signed(b_o_tdata), 0);
    beat(1'b0, 0);
    check("clr_after_tdata", $signed(b_o_tdata), 0);
    check("clr_after_tchan", b_o_tchan, 0);
    beat(1'b0, 0);
    check("clr_after2_tchan", b_o_tchan, 1);

    // 8-bit natural wrap
    do_reset();
    beat(1'b1, 100);
    check("w8_ctl_tlast", c_o_tlast, 1);
    for (int k = 0; k < 4; k++) begin
      beat(1'b0, 0);
      check($sformatf("w8_d%0d", k), $signed(c_o_tdata), exp_c[k]);
    end

    // Reset mid-stream on a
    do_reset();
    beat(1'b1, 4096);
    beat(1'b0, 0);
    beat(1'b0, 0);
    check("mrst_pre_tdata", $signed(a_o_tdata), 4096);
    check("mrst_pre_tvalid", a_o_tvalid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_tvalid", a_o_tvalid, 0);
    check("mrst_tdata", $signed(a_o_tdata), 0);
    beat(1'b0, 0);
    check("mrst_after_tdata", $signed(a_o_tdata), 0);
    check("mrst_after_tchan", a_o_tchan, 0);
    check("mrst_after_tvalid", a_o_tvalid, 1);
    beat(1'b0, 0);
    check("mrst_after2_tdata", $signed(a_o_tdata), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
